// File: rtl/mul_sequencer.sv
// Control stage wrapping an iterative unsigned multiplier core: sign handling,
// start/done handshake, condition flags and even/odd register-pair writeback.
module mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_signed,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic [3:0]           req_reg,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_multiplier,
  output logic [WIDTH-1:0]     mul_multiplicand,
  input  logic [2*WIDTH-1:0]   mul_result,
  input  logic                 mul_done,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [3:0]           wb_reg,
  output logic [WIDTH-1:0]     wb_data,
  output logic                 wb_last,
  output logic                 cc_zero,
  output logic                 cc_neg,
  output logic                 cc_ovf
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_FIX, S_WB_HI, S_WB_LO
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mag_a_q, mag_a_d;
  logic [WIDTH-1:0]  mag_b_q, mag_b_d;
  logic              signed_q, signed_d;
  logic              neg_res_q, neg_res_d;
  logic [3:0]        reg_q, reg_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              req_ready_q, req_ready_d;
  logic              mul_start_q, mul_start_d;
  logic              wb_valid_q, wb_valid_d;
  logic [3:0]        wb_reg_q, wb_reg_d;
  logic [WIDTH-1:0]  wb_data_q, wb_data_d;
  logic              wb_last_q, wb_last_d;
  logic [PW-1:0]     fixed_p;

  // Magnitude of a two's-complement word; the most negative value maps to itself
  // and is then treated as unsigned by the core.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? ((~x) + WIDTH'(1)) : x;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      signed_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      reg_q       <= '0;
      prod_q      <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      req_ready_q <= 1'b1;
      mul_start_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      wb_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      signed_q    <= signed_d;
      neg_res_q   <= neg_res_d;
      reg_q       <= reg_d;
      prod_q      <= prod_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      req_ready_q <= req_ready_d;
      mul_start_q <= mul_start_d;
      wb_valid_q  <= wb_valid_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      wb_last_q   <= wb_last_d;
    end
  end

  // Signed products are formed as magnitudes and negated back here.
  assign fixed_p = neg_res_q ? ((~prod_q) + PW'(1)) : prod_q;

  always_comb begin
    state_d   = state_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    signed_d  = signed_q;
    neg_res_d = neg_res_q;
    reg_d     = reg_q;
    prod_d    = prod_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mag_a_d   = req_signed ? magnitude(req_a) : req_a;
          mag_b_d   = req_signed ? magnitude(req_b) : req_b;
          signed_d  = req_signed;
          neg_res_d = req_signed & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
          reg_d     = req_reg;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!mul_done) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          prod_d  = mul_result;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        prod_d  = fixed_p;
        zero_d  = (fixed_p == '0);
        neg_d   = signed_q & fixed_p[PW-1];
        ovf_d   = signed_q ? (fixed_p[PW-1:WIDTH] != {WIDTH{fixed_p[WIDTH-1]}})
                           : (fixed_p[PW-1:WIDTH] != '0);
        state_d = reg_q[0] ? S_WB_LO : S_WB_HI;
      end
      S_WB_HI: begin
        if (wb_ready) state_d = S_WB_LO;
      end
      S_WB_LO: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered images of the state being entered.
    req_ready_d = (state_d == S_IDLE);
    mul_start_d = (state_d == S_LAUNCH);
    wb_valid_d  = (state_d == S_WB_HI) || (state_d == S_WB_LO);
    wb_last_d   = (state_d == S_WB_LO);
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    if (state_d == S_WB_HI) begin
      wb_reg_d  = reg_d;
      wb_data_d = prod_d[PW-1:WIDTH];
    end else if (state_d == S_WB_LO) begin
      wb_reg_d  = reg_d | 4'd1;
      wb_data_d = prod_d[WIDTH-1:0];
    end
  end

  assign req_ready        = req_ready_q;
  assign mul_start        = mul_start_q;
  assign mul_multiplier   = mag_a_q;
  assign mul_multiplicand = mag_b_q;
  assign wb_valid         = wb_valid_q;
  assign wb_reg           = wb_reg_q;
  assign wb_data          = wb_data_q;
  assign wb_last          = wb_last_q;
  assign cc_zero          = zero_q;
  assign cc_neg           = neg_q;
  assign cc_ovf           = ovf_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural multi-cycle multiplier core.
module tb_mul_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_signed = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_reg = '0;
  logic        mul_start;
  logic [31:0] mul_multiplier;
  logic [31:0] mul_multiplicand;
  logic [63:0] mul_result;
  logic        mul_done;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_last;
  logic        cc_zero;
  logic        cc_neg;
  logic        cc_ovf;

  int checks = 0;
  int errors = 0;

  mul_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_a(req_a), .req_b(req_b), .req_reg(req_reg),
    .mul_start(mul_start), .mul_multiplier(mul_multiplier),
    .mul_multiplicand(mul_multiplicand), .mul_result(mul_result),
    .mul_done(mul_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg),
    .wb_data(wb_data), .wb_last(wb_last),
    .cc_zero(cc_zero), .cc_neg(cc_neg), .cc_ovf(cc_ovf)
  );

  always #5 clock = ~clock;

  // Core model: drops done on start, computes the unsigned product, raises done later.
  logic [2:0] core_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mul_done   <= 1'b1;
      core_cnt   <= '0;
      mul_result <= '0;
    end else if (mul_done && mul_start) begin
      mul_done   <= 1'b0;
      core_cnt   <= 3'd3;
      mul_result <= {32'd0, mul_multiplier} * {32'd0, mul_multiplicand};
    end else if (!mul_done) begin
      if (core_cnt == 3'd0) mul_done <= 1'b1;
      else core_cnt <= core_cnt - 3'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] r);
    bit ok = 0;
    req_valid = 1'b1; req_signed = s; req_a = a; req_b = b; req_reg = r;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clock);
    end
    check("req_accept", 64'(ok), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (wb_valid) break;
      @(negedge clock);
    end
    check(tag, 64'(wb_valid), 64'd1);
  endtask

  task automatic expect_beat(input string tag, input logic [3:0] r, input logic [31:0] d,
                             input logic last, input bit flags,
                             input logic z, input logic n, input logic o);
    wait_valid({tag, "_valid"});
    check({tag, "_reg"}, 64'(wb_reg), 64'(r));
    check({tag, "_data"}, 64'(wb_data), 64'(d));
    check({tag, "_last"}, 64'(wb_last), 64'(last));
    if (flags) begin
      check({tag, "_zero"}, 64'(cc_zero), 64'(z));
      check({tag, "_neg"}, 64'(cc_neg), 64'(n));
      check({tag, "_ovf"}, 64'(cc_ovf), 64'(o));
    end
    @(negedge clock);
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_last", 64'(wb_last), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    check("rst_operand", 64'(mul_multiplier), 64'd0);
    check("rst_flags", 64'({cc_zero, cc_neg, cc_ovf}), 64'd0);

    // 1: unsigned 35*17 to R2/R3, with first-beat latency
    send_req(1'b0, 32'd35, 32'd17, 4'd2);
    check("t1_ready_busy", 64'(req_ready), 64'd0);
    for (int i = 0; i < 20 && mul_done; i++) @(negedge clock);
    check("t1_core_busy", 64'(mul_done), 64'd0);
    for (int i = 0; i < 20 && !mul_done; i++) @(negedge clock);
    check("t1_core_done", 64'(mul_done), 64'd1);
    @(negedge clock);
    check("t1_lat_early", 64'(wb_valid), 64'd0);
    @(negedge clock);
    check("t1_lat_on", 64'(wb_valid), 64'd1);
    expect_beat("t1_hi", 4'd2, 32'h0000_0000, 1'b0, 0, 0, 0, 0);
    expect_beat("t1_lo", 4'd3, 32'h0000_0253, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    check("t1_ready_idle", 64'(req_ready), 64'd1);

    // 2: signed -3*5
    send_req(1'b1, 32'hFFFF_FFFD, 32'd5, 4'd4);
    expect_beat("t2_hi", 4'd4, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 0);
    expect_beat("t2_lo", 4'd5, 32'hFFFF_FFF1, 1'b1, 1, 1'b0, 1'b1, 1'b0);

    // 3: signed most-negative squared
    send_req(1'b1, 32'h8000_0000, 32'h8000_0000, 4'd6);
    expect_beat("t3_hi", 4'd6, 32'h4000_0000, 1'b0, 0, 0, 0, 0);
    expect_beat("t3_lo", 4'd7, 32'h0000_0000, 1'b1, 1, 1'b0, 1'b0, 1'b1);

    // 4: odd destination, single beat
    send_req(1'b0, 32'hFFFF_FFFF, 32'd2, 4'd7);
    expect_beat("t4_lo", 4'd7, 32'hFFFF_FFFE, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    check("t4_single", 64'(wb_valid), 64'd0);

    // 5: signed zero product with writeback stall
    wb_ready = 1'b0;
    send_req(1'b1, 32'd0, 32'hFFFF_FFF9, 4'd8);
    wait_valid("t5_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t5_hold", 64'({wb_valid, wb_reg, wb_last, wb_data}), {27'd0, 1'b1, 4'd8, 1'b0, 32'd0});
      check("t5_ready_busy", 64'(req_ready), 64'd0);
    end
    wb_ready = 1'b1;
    expect_beat("t5_hi", 4'd8, 32'd0, 1'b0, 0, 0, 0, 0);
    check("t5_ready_mid", 64'(req_ready), 64'd0);
    expect_beat("t5_lo", 4'd9, 32'd0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    check("t5_ready_idle", 64'(req_ready), 64'd1);

    // 6: reset during WAIT drops the operation
    send_req(1'b0, 32'd100, 32'd3, 4'd2);
    for (int i = 0; i < 20 && mul_done; i++) @(negedge clock);
    check("t6_core_busy", 64'(mul_done), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_rst_valid", 64'(wb_valid), 64'd0);
    check("t6_rst_start", 64'(mul_start), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("t6_ready", 64'(req_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (wb_valid || mul_start) seen++;
      @(negedge clock);
    end
    check("t6_no_wb", 64'(seen), 64'd0);
    send_req(1'b0, 32'd6, 32'd7, 4'd0);
    expect_beat("t6_hi", 4'd0, 32'd0, 1'b0, 0, 0, 0, 0);
    expect_beat("t6_lo", 4'd1, 32'd42, 1'b1, 1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
